toggle_event_rx: RTL and testbench

Receiver end of the two-phase toggle signalling scheme driven by our T-flip-flop event senders. The sender flips a level once per event. This block synchronises that level into the local `clk` domain, turns each level change into one event, and buffers pending events in a saturating counter. A downstream consumer drains the events through a valid/ready handshake. A running event total and a sticky overflow flag are kept for status. An optional acknowledge toggle closes the loop back to the sender.

---
 rtl/toggle_event_rx.sv | 131 +++++++++++++
 tb/tb_toggle_event_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_rx.sv
// Two-phase toggle receiver: synchronises tog_in, turns each level change into one
// buffered event, drains via valid/ready. Optional macro TOGGLE_ACK_EN adds tog_ack.
module toggle_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tog_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  evt_total,
    output logic              overflow,
    input  logic              ovf_clr
`ifdef TOGGLE_ACK_EN
    ,
    output logic              tog_ack
`endif
);

    typedef enum logic {ST_ARM, ST_ACTIVE} state_t;

    localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(SYNC_STAGES);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ARM_W-1:0]   r_arm_cnt;
    logic [ARM_W-1:0]   w_arm_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic               r_tog_q;
    logic               w_tog_s;
    logic               w_det;
    logic               w_pop;
    logic               w_ovf_set;
    logic [PEND_W-1:0]  w_pend_nxt;
    logic [PEND_W-1:0]  r_pending;
    logic               r_valid;
    logic [CNT_W-1:0]   r_total;
    logic               r_ovf;

    assign w_tog_s = r_sync[SYNC_STAGES-1];

    // The chain and reference flop shift in ARM too, so tog_in at reset becomes the baseline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_tog_q <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], tog_in};
            r_tog_q <= w_tog_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_ARM;
            r_arm_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_arm_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_arm_cnt_nxt = r_arm_cnt;
        w_det         = 1'b0;
        case (r_state)
            ST_ARM: begin
                if (r_arm_cnt == ARM_LAST) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_arm_cnt_nxt = '0;
                end else begin
                    w_arm_cnt_nxt = r_arm_cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                w_det = (w_tog_s != r_tog_q);
            end
            default: w_state_nxt = ST_ARM;
        endcase
    end

    assign w_pop = r_valid && evt_ready;

    // A coincident detect and pop cancel out, so a full buffer never flags overflow then.
    always_comb begin
        w_pend_nxt = r_pending;
        w_ovf_set  = 1'b0;
        if (w_det && !w_pop) begin
            if (r_pending == PEND_MAX) w_ovf_set = 1'b1;
            else                       w_pend_nxt = r_pending + 1'b1;
        end else if (w_pop && !w_det) begin
            w_pend_nxt = r_pending - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_total   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_valid   <= (w_pend_nxt != '0);
            if (w_det)          r_total <= r_total + 1'b1;
            if (w_ovf_set)      r_ovf   <= 1'b1;
            else if (ovf_clr)   r_ovf   <= 1'b0;
        end
    end

`ifdef TOGGLE_ACK_EN
    logic r_ack;
    always_ff @(posedge clk) begin
        if (reset)      r_ack <= 1'b0;
        else if (w_pop) r_ack <= ~r_ack;
    end
    assign tog_ack = r_ack;
`endif

    assign evt_valid = r_valid;
    assign pending   = r_pending;
    assign evt_total = r_total;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Directed bench for toggle_event_rx (default parameters), table-driven plus sequences.
module tb_toggle_event_rx;

    localparam int SYNC_STAGES = 2;
    localparam int PEND_W      = 4;
    localparam int CNT_W       = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tog_in = 1'b0;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [PEND_W-1:0] pending;
    logic [CNT_W-1:0]  evt_total;
    logic              overflow;
    logic              ovf_clr = 1'b0;
`ifdef TOGGLE_ACK_EN
    logic              tog_ack;
`endif

    int checks = 0;
    int errors = 0;

    toggle_event_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .PEND_W     (PEND_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tog_in   (tog_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .pending  (pending),
        .evt_total(evt_total),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`ifdef TOGGLE_ACK_EN
        ,
        .tog_ack  (tog_ack)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic tog;
        logic rdy;
        logic clr;
        int   pend;
        logic vld;
        int   tot;
        logic ovf;
        logic ack;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(logic t, logic r, logic c, int p, logic v, int s, logic o, logic a);
        vec_t x;
        x.tog = t; x.rdy = r; x.clr = c; x.pend = p;
        x.vld = v; x.tot = s; x.ovf = o; x.ack = a;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ack(input string name, input int exp);
`ifdef TOGGLE_ACK_EN
        chk(name, int'(tog_ack), exp);
`endif
    endtask

    // Reset with tog_in held at lvl, check reset values, then wait out ARM.
    task automatic do_reset(input logic lvl);
        tog_in    = lvl;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        reset     = 1'b1;
        tick();
        chk("rst_pending", int'(pending), 0);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_total", int'(evt_total), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk_ack("rst_ack", 0);
        reset = 1'b0;
        repeat (SYNC_STAGES + 1) tick();
    endtask

    task automatic toggles(input int n);
        for (int i = 0; i < n; i++) begin
            tog_in = ~tog_in;
            repeat (3) tick();
        end
    endtask

    initial begin
        vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        vt[2]  = mk(1, 0, 0, 1, 1, 1, 0, 0);
        vt[3]  = mk(1, 1, 0, 0, 0, 1, 0, 1);
        vt[4]  = mk(0, 0, 0, 0, 0, 1, 0, 1);
        vt[5]  = mk(0, 0, 0, 0, 0, 1, 0, 1);
        vt[6]  = mk(0, 0, 0, 1, 1, 2, 0, 1);
        vt[7]  = mk(1, 0, 0, 1, 1, 2, 0, 1);
        vt[8]  = mk(1, 0, 0, 1, 1, 2, 0, 1);
        vt[9]  = mk(1, 1, 0, 1, 1, 3, 0, 0);
        vt[10] = mk(1, 1, 0, 0, 0, 3, 0, 1);
        vt[11] = mk(1, 1, 0, 0, 0, 3, 0, 1);
        vt[12] = mk(1, 0, 1, 0, 0, 3, 0, 1);

        // Baseline level 1 through reset and ARM: never counted
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("base_valid", int'(evt_valid), 0);
            chk("base_total", int'(evt_total), 0);
        end

        // Cycle-by-cycle vectors: single event, pop, coincident detect+pop, ignored ready
        do_reset(1'b0);
        for (int i = 0; i < 13; i++) begin
            tog_in    = vt[i].tog;
            evt_ready = vt[i].rdy;
            ovf_clr   = vt[i].clr;
            tick();
            chk($sformatf("vec%0d_pending", i), int'(pending), vt[i].pend);
            chk($sformatf("vec%0d_valid", i), int'(evt_valid), int'(vt[i].vld));
            chk($sformatf("vec%0d_total", i), int'(evt_total), vt[i].tot);
            chk($sformatf("vec%0d_overflow", i), int'(overflow), int'(vt[i].ovf));
            chk_ack($sformatf("vec%0d_ack", i), int'(vt[i].ack));
        end
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Overflow: 17 toggles into a 15-deep buffer
        do_reset(1'b0);
        toggles(17);
        chk("ovf_pending", int'(pending), 15);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_total", int'(evt_total), 17);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr_flag", int'(overflow), 0);
        chk("ovf_clr_pending", int'(pending), 15);

        // Detect and pop on the same edge while full
        tog_in = ~tog_in;
        repeat (2) tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("coin_pending", int'(pending), 15);
        chk("coin_overflow", int'(overflow), 0);
        chk("coin_total", int'(evt_total), 18);
        chk_ack("coin_ack", 1);

        // Dropped event with ovf_clr on the same edge: set wins
        tog_in = ~tog_in;
        repeat (2) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("setwins_overflow", int'(overflow), 1);
        chk("setwins_total", int'(evt_total), 19);
        chk("setwins_pending", int'(pending), 15);

        // Wrap-around with continuous draining
        do_reset(1'b0);
        evt_ready = 1'b1;
        toggles(255);
        chk("wrap255_total", int'(evt_total), 255);
        toggles(1);
        repeat (2) tick();
        chk("wrap_total", int'(evt_total), 0);
        chk("wrap_pending", int'(pending), 0);
        chk("wrap_overflow", int'(overflow), 0);
        chk_ack("wrap_ack", 0);
        evt_ready = 1'b0;

        // Reset mid-burst, then the current level becomes the new baseline
        do_reset(1'b0);
        toggles(5);
        chk("burst_pending", int'(pending), 5);
        reset = 1'b1;
        tick();
        chk("midrst_pending", int'(pending), 0);
        chk("midrst_valid", int'(evt_valid), 0);
        chk("midrst_total", int'(evt_total), 0);
        chk("midrst_overflow", int'(overflow), 0);
        chk_ack("midrst_ack", 0);
        reset = 1'b0;
        repeat (SYNC_STAGES + 1 + 10) tick();
        chk("rearm_pending", int'(pending), 0);
        chk("rearm_valid", int'(evt_valid), 0);
        chk("rearm_total", int'(evt_total), 0);
        toggles(1);
        chk("rearm_evt_pending", int'(pending), 1);
        chk("rearm_evt_total", int'(evt_total), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
